// File: rtl/hms_pass_pkg.sv
// Shared definitions for the merge-pass controller: FSM encoding and the
// terminal sentinel record injected once a way's run is exhausted.
package hms_pass_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_FEED,
        ST_DONE
    } pass_state_e;

    localparam int KEYW_DEF = 32;
    localparam logic [KEYW_DEF-1:0] SENTINEL_KEY = '1;

    // Wide enough for any record; callers slice the low DATW bits.
    localparam int MAX_RECW = 1024;

    // Sentinel record: zero payload, all-ones key in the low keyw bits.
    function automatic logic [MAX_RECW-1:0] sentinel_rec(input int keyw);
        logic [MAX_RECW-1:0] r;
        r = '0;
        for (int b = 0; b < MAX_RECW; b++) begin
            if (b < keyw) r[b] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hms_way_feeder.sv
// One merge-tree input way: counts records of the current run, throttles on
// the registered full flag and switches to sentinel injection at run end.
module hms_way_feeder
    import hms_pass_pkg::*;
#(
    parameter int DATW = 64,
    parameter int KEYW = 32,
    parameter int RLW  = 32
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic            clr,
    input  logic            feed_en,
    input  logic [RLW-1:0]  runlen,
    input  logic            src_valid,
    input  logic [DATW-1:0] src_data,
    input  logic            tree_ful,
    output logic            src_ready,
    output logic            tree_dinen,
    output logic [DATW-1:0] tree_din,
    output logic            stall
);

    localparam logic [MAX_RECW-1:0] SENT_FULL = sentinel_rec(KEYW);
    localparam logic [DATW-1:0]     SENT_REC  = SENT_FULL[DATW-1:0];

    logic           stall_q, stall_d;
    logic [RLW-1:0] in_cnt_q, in_cnt_d;

    always_comb begin
        stall_d    = tree_ful;
        in_cnt_d   = in_cnt_q;
        src_ready  = 1'b0;
        tree_dinen = 1'b0;
        tree_din   = '0;
        if (clr) begin
            in_cnt_d = '0;
        end else if (feed_en) begin
            if (in_cnt_q != runlen) begin
                src_ready  = ~stall_q;
                tree_dinen = ~stall_q & src_valid;
                tree_din   = src_data;
                if (src_valid && !stall_q) in_cnt_d = in_cnt_q + RLW'(1);
            end else begin
                // Run exhausted: keep pushing sentinels so the tree can drain.
                tree_dinen = ~stall_q;
                tree_din   = SENT_REC;
            end
        end
    end

    assign stall = stall_q;

    always_ff @(posedge CLK) begin
        if (rst) begin
            stall_q  <= 1'b0;
            in_cnt_q <= '0;
        end else begin
            stall_q  <= stall_d;
            in_cnt_q <= in_cnt_d;
        end
    end

endmodule

// File: rtl/hms_pass_ctrl.sv
// Merge-pass sequencer for a 2^E_LOG-way merge tree: init, feed one run per
// way plus sentinels, count output beats, pulse done. `HMS_PASS_STATS_EN adds
// FEED cycle / stall counters.
module hms_pass_ctrl
    import hms_pass_pkg::*;
#(
    parameter int E_LOG = 5,
    parameter int DATW  = 64,
    parameter int KEYW  = 32,
    parameter int RLW   = 32,
    localparam int W    = 1 << E_LOG
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [RLW-1:0]    cfg_runlen,
    input  logic [W-1:0]      src_valid,
    input  logic [DATW*W-1:0] src_data,
    output logic [W-1:0]      src_ready,
    output logic              tree_init,
    output logic [DATW*W-1:0] tree_din,
    output logic [W-1:0]      tree_dinen,
    input  logic [W-1:0]      tree_ful,
    input  logic [KEYW-1:0]   tree_dot_key0,
    input  logic              tree_doten,
    output logic              busy,
    output logic              done,
    output logic              err_sentinel
`ifdef HMS_PASS_STATS_EN
    ,
    output logic [31:0]       stat_cycles,
    output logic [31:0]       stat_stalls
`endif
);

    pass_state_e    state_q, state_d;
    logic [RLW-1:0] runlen_q, runlen_d;
    logic [RLW-1:0] out_cnt_q, out_cnt_d;
    logic           err_q, err_d;
    logic           feed_en;
    logic [W-1:0]   stall_w;

    always_comb begin
        state_d   = state_q;
        runlen_d  = runlen_q;
        out_cnt_d = out_cnt_q;
        err_d     = err_q;
        busy      = (state_q != ST_IDLE);
        tree_init = (state_q == ST_INIT);
        feed_en   = (state_q == ST_FEED);
        done      = 1'b0;
        if (abort && busy) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_runlen == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d  = ST_INIT;
                            runlen_d = cfg_runlen;
                            err_d    = 1'b0;
                        end
                    end
                end
                ST_INIT: begin
                    out_cnt_d = '0;
                    state_d   = ST_FEED;
                end
                ST_FEED: begin
                    if (tree_doten) begin
                        out_cnt_d = out_cnt_q + RLW'(1);
                        if (&tree_dot_key0) err_d = 1'b1;
                        if (out_cnt_q == runlen_q - RLW'(1)) state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            runlen_q  <= '0;
            out_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            runlen_q  <= runlen_d;
            out_cnt_q <= out_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err_sentinel = err_q;

    for (genvar i = 0; i < W; i++) begin : g_way
        hms_way_feeder #(
            .DATW (DATW),
            .KEYW (KEYW),
            .RLW  (RLW)
        ) u_way (
            .CLK        (CLK),
            .rst        (rst),
            .clr        (tree_init),
            .feed_en    (feed_en),
            .runlen     (runlen_q),
            .src_valid  (src_valid[i]),
            .src_data   (src_data[DATW*i +: DATW]),
            .tree_ful   (tree_ful[i]),
            .src_ready  (src_ready[i]),
            .tree_dinen (tree_dinen[i]),
            .tree_din   (tree_din[DATW*i +: DATW]),
            .stall      (stall_w[i])
        );
    end

`ifdef HMS_PASS_STATS_EN
    logic [31:0] stat_cycles_q, stat_cycles_d;
    logic [31:0] stat_stalls_q, stat_stalls_d;

    always_comb begin
        stat_cycles_d = stat_cycles_q;
        stat_stalls_d = stat_stalls_q;
        if (state_q == ST_INIT) begin
            stat_cycles_d = '0;
            stat_stalls_d = '0;
        end else if (state_q == ST_FEED) begin
            stat_cycles_d = stat_cycles_q + 32'd1;
            if (|stall_w) stat_stalls_d = stat_stalls_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            stat_cycles_q <= '0;
            stat_stalls_q <= '0;
        end else begin
            stat_cycles_q <= stat_cycles_d;
            stat_stalls_q <= stat_stalls_d;
        end
    end

    assign stat_cycles = stat_cycles_q;
    assign stat_stalls = stat_stalls_q;
`endif

endmodule
